// File: rtl/axi_read_arbiter_pkg.sv
// Shared read/write interconnect types: arbiter FSM states, slave-select width, slave indices.
// No logic; widths here are the interconnect-wide defaults.
// Imported by the read arbiter and reused by the AW-side arbiter.
package axi_read_arbiter_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_LEN_BITS   = 8;
  localparam int AXI_SEL_BITS   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [AXI_SEL_BITS-1:0] {
    SLV_S0 = 2'd0,
    SLV_S1 = 2'd1,
    SLV_S2 = 2'd2,
    SLV_S3 = 2'd3
  } slv_idx_e;

endpackage

// File: rtl/axi_rr_pick2.sv
// Two-way round-robin chooser: one-hot pick, bit0 = m0, bit1 = m1.
// Purely combinational, zero latency.
// No flow control; the caller decides when the pick is consumed.
module axi_rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_m1,
  output logic [1:0] pick
);

  always_comb begin
    pick = {req1, req0};
    // On contention the master that did not win last time goes first.
    if (req0 && req1) pick = last_m1 ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Read-path arbiter: grants AR/R to m0 or m1 round-robin, one outstanding burst, checks RLAST vs ARLEN.
// Grant one edge after request; DATA->IDLE one edge after the RLAST beat; len_err registered.
// Stalls on arready and rvalid/rready; the grant is held through both stalls.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int LEN_BITS = AXI_LEN_BITS,
  parameter int SEL_BITS = AXI_SEL_BITS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                m0_arvalid,
  input  logic                m1_arvalid,
  input  logic [SEL_BITS-1:0] m0_arsel,
  input  logic [SEL_BITS-1:0] m1_arsel,
  input  logic [LEN_BITS-1:0] m0_arlen,
  input  logic [LEN_BITS-1:0] m1_arlen,
  input  logic                arvalid,
  input  logic                arready,
  input  logic                rvalid,
  input  logic                rready,
  input  logic                rlast,
  output logic                m0_rgrnt,
  output logic                m1_rgrnt,
  output logic [SEL_BITS-1:0] s_rsel,
  output logic                busy,
  output logic                len_err
);

  localparam int CNT_BITS = LEN_BITS + 1;

  rd_state_e           state_q, state_d;
  logic                last_m1_q, last_m1_d;
  logic                m0_grnt_q, m0_grnt_d;
  logic                m1_grnt_q, m1_grnt_d;
  logic [SEL_BITS-1:0] s_rsel_q, s_rsel_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [CNT_BITS-1:0] beat_q, beat_d;
  logic                len_err_q, len_err_d;
  logic                err_seen_q, err_seen_d;
  logic [1:0]          pick;
  logic [CNT_BITS-1:0] len_ext;
  logic                r_hs;

  axi_rr_pick2 u_pick (
    .req0    (m0_arvalid),
    .req1    (m1_arvalid),
    .last_m1 (last_m1_q),
    .pick    (pick)
  );

  assign len_ext = {1'b0, len_q};
  assign r_hs    = rvalid && rready;

  always_comb begin
    state_d    = state_q;
    last_m1_d  = last_m1_q;
    m0_grnt_d  = m0_grnt_q;
    m1_grnt_d  = m1_grnt_q;
    s_rsel_d   = s_rsel_q;
    len_d      = len_q;
    beat_d     = beat_q;
    len_err_d  = 1'b0;
    err_seen_d = err_seen_q;
    case (state_q)
      ST_IDLE: begin
        if (|pick) begin
          m0_grnt_d = pick[0];
          m1_grnt_d = pick[1];
          s_rsel_d  = pick[1] ? m1_arsel : m0_arsel;
          len_d     = pick[1] ? m1_arlen : m0_arlen;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (arvalid && arready) begin
          beat_d     = '0;
          err_seen_d = 1'b0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_hs) begin
          if (!(&beat_q)) beat_d = beat_q + 1'b1;
          if (rlast) begin
            // beat_q is the index of this beat; the last one must be len_q.
            len_err_d = (beat_q != len_ext) && !err_seen_q;
            last_m1_d = m1_grnt_q;
            m0_grnt_d = 1'b0;
            m1_grnt_d = 1'b0;
            state_d   = ST_IDLE;
          end else if ((beat_q > len_ext) && !err_seen_q) begin
            len_err_d  = 1'b1;
            err_seen_d = 1'b1;
          end
        end
      end
      default: begin
        m0_grnt_d = 1'b0;
        m1_grnt_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      last_m1_q  <= 1'b1;
      m0_grnt_q  <= 1'b0;
      m1_grnt_q  <= 1'b0;
      s_rsel_q   <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      len_err_q  <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_m1_q  <= last_m1_d;
      m0_grnt_q  <= m0_grnt_d;
      m1_grnt_q  <= m1_grnt_d;
      s_rsel_q   <= s_rsel_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      len_err_q  <= len_err_d;
      err_seen_q <= err_seen_d;
    end
  end

  assign m0_rgrnt = m0_grnt_q;
  assign m1_rgrnt = m1_grnt_q;
  assign s_rsel   = s_rsel_q;
  assign busy     = (state_q != ST_IDLE);
  assign len_err  = len_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: reset, contention, single burst, length errors, R stall, async reset.
module tb_axi_read_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       m0_arvalid, m1_arvalid;
  logic [1:0] m0_arsel, m1_arsel;
  logic [7:0] m0_arlen, m1_arlen;
  logic       arvalid, arready;
  logic       rvalid, rready, rlast;
  logic       m0_rgrnt, m1_rgrnt;
  logic [1:0] s_rsel;
  logic       busy, len_err;

  int total = 0;
  int bad   = 0;

  // Model of the AR mux: only the granted master's ARVALID reaches the slave side.
  assign arvalid = (m0_rgrnt & m0_arvalid) | (m1_rgrnt & m1_arvalid);

  axi_read_arbiter #(.LEN_BITS(8), .SEL_BITS(2)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .m0_arvalid (m0_arvalid),
    .m1_arvalid (m1_arvalid),
    .m0_arsel   (m0_arsel),
    .m1_arsel   (m1_arsel),
    .m0_arlen   (m0_arlen),
    .m1_arlen   (m1_arlen),
    .arvalid    (arvalid),
    .arready    (arready),
    .rvalid     (rvalid),
    .rready     (rready),
    .rlast      (rlast),
    .m0_rgrnt   (m0_rgrnt),
    .m1_rgrnt   (m1_rgrnt),
    .s_rsel     (s_rsel),
    .busy       (busy),
    .len_err    (len_err)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // m0 request through the address handshake; leaves the FSM in DATA.
  task automatic m0_addr(input logic [1:0] sel, input logic [7:0] len);
    m0_arsel   = sel;
    m0_arlen   = len;
    m0_arvalid = 1'b1;
    tick();
    arready = 1'b1;
    tick();
    arready    = 1'b0;
    m0_arvalid = 1'b0;
  endtask

  // n beats with RLAST on the last, plus one trailing cycle; reports len_err pulses and grant hold.
  task automatic run_beats(input int n, output int pulses, output int pulse_idx, output int held);
    pulses    = 0;
    pulse_idx = -1;
    held      = 0;
    rvalid    = 1'b1;
    rready    = 1'b1;
    for (int i = 0; i < n; i++) begin
      rlast = (i == n - 1);
      tick();
      if (len_err) begin
        pulses++;
        pulse_idx = i;
      end
      if (i < n - 1 && m0_rgrnt) held++;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    tick();
    if (len_err) pulses++;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    m0_arsel = 2'd0; m1_arsel = 2'd0;
    m0_arlen = 8'd0; m1_arlen = 8'd0;
    arready = 1'b0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    repeat (2) tick();
    total++; if (m0_rgrnt !== 1'b0) begin bad++; $display("FAIL reset_m0_rgrnt: got %b want 0", m0_rgrnt); end
    total++; if (m1_rgrnt !== 1'b0) begin bad++; $display("FAIL reset_m1_rgrnt: got %b want 0", m1_rgrnt); end
    total++; if (s_rsel !== 2'd0) begin bad++; $display("FAIL reset_s_rsel: got %0d want 0", s_rsel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (len_err !== 1'b0) begin bad++; $display("FAIL reset_len_err: got %b want 0", len_err); end
    #2 rst_ni = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_req_busy: got %b want 0", busy); end
  endtask

  task automatic test_contention;
    logic [1:0] exp_g;
    logic       exp_busy;
    m0_arsel = 2'd2; m1_arsel = 2'd3;
    m0_arlen = 8'd0; m1_arlen = 8'd0;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    arready = 1'b1; rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    // Each transaction is grant(ADDR), DATA, then one IDLE cycle; winners alternate m0, m1, ...
    for (int e = 0; e < 12; e++) begin
      tick();
      exp_busy = (e % 3) != 2;
      exp_g    = !exp_busy ? 2'b00 : (((e / 3) % 2) == 1 ? 2'b10 : 2'b01);
      total++;
      if ({m1_rgrnt, m0_rgrnt} !== exp_g) begin
        bad++; $display("FAIL contention_grant[%0d]: got %b want %b", e, {m1_rgrnt, m0_rgrnt}, exp_g);
      end
      total++;
      if (busy !== exp_busy) begin bad++; $display("FAIL contention_busy[%0d]: got %b want %b", e, busy, exp_busy); end
      if (exp_busy) begin
        total++;
        if (s_rsel !== (exp_g[1] ? 2'd3 : 2'd2)) begin
          bad++; $display("FAIL contention_sel[%0d]: got %0d want %0d", e, s_rsel, exp_g[1] ? 3 : 2);
        end
      end
      total++;
      if (len_err !== 1'b0) begin bad++; $display("FAIL contention_len_err[%0d]: got %b want 0", e, len_err); end
    end
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_single;
    m0_arsel = 2'd1; m0_arlen = 8'd3; m0_arvalid = 1'b1;
    tick();
    total++; if ({m1_rgrnt, m0_rgrnt} !== 2'b01) begin bad++; $display("FAIL single_grant: got %b want 01", {m1_rgrnt, m0_rgrnt}); end
    total++; if (s_rsel !== 2'd1) begin bad++; $display("FAIL single_sel: got %0d want 1", s_rsel); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    repeat (2) begin
      tick();
      total++; if (m0_rgrnt !== 1'b1) begin bad++; $display("FAIL single_addr_hold: got %b want 1", m0_rgrnt); end
    end
    arready = 1'b1;
    tick();
    arready = 1'b0; m0_arvalid = 1'b0;
    rvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rlast = (i == 3);
      tick();
      if (i < 3) begin
        total++; if (m0_rgrnt !== 1'b1) begin bad++; $display("FAIL single_data_hold[%0d]: got %b want 1", i, m0_rgrnt); end
      end
      total++; if (len_err !== 1'b0) begin bad++; $display("FAIL single_len_err[%0d]: got %b want 0", i, len_err); end
    end
    rvalid = 1'b0; rlast = 1'b0;
    total++; if ({m1_rgrnt, m0_rgrnt} !== 2'b00) begin bad++; $display("FAIL single_release: got %b want 00", {m1_rgrnt, m0_rgrnt}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", busy); end
    tick();
    total++; if (len_err !== 1'b0) begin bad++; $display("FAIL single_len_err_after: got %b want 0", len_err); end
  endtask

  task automatic test_short_burst;
    int pulses, idx, held;
    m0_addr(2'd0, 8'd3);
    run_beats(2, pulses, idx, held);
    total++; if (pulses !== 1) begin bad++; $display("FAIL short_pulses: got %0d want 1", pulses); end
    total++; if (idx !== 1) begin bad++; $display("FAIL short_pulse_beat: got %0d want 1", idx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL short_idle: got %b want 0", busy); end
  endtask

  task automatic test_long_burst;
    int pulses, idx, held;
    m0_addr(2'd2, 8'd1);
    run_beats(4, pulses, idx, held);
    total++; if (pulses !== 1) begin bad++; $display("FAIL long_pulses: got %0d want 1", pulses); end
    total++; if (idx !== 2) begin bad++; $display("FAIL long_pulse_beat: got %0d want 2", idx); end
    total++; if (held !== 3) begin bad++; $display("FAIL long_grant_held: got %0d want 3", held); end
    total++; if (m0_rgrnt !== 1'b0) begin bad++; $display("FAIL long_release: got %b want 0", m0_rgrnt); end
  endtask

  task automatic test_backpressure;
    m0_addr(2'd1, 8'd3);
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b0;
    repeat (2) tick();
    rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (m0_rgrnt !== 1'b1) begin bad++; $display("FAIL bp_grant_hold[%0d]: got %b want 1", i, m0_rgrnt); end
      total++; if (len_err !== 1'b0) begin bad++; $display("FAIL bp_len_err[%0d]: got %b want 0", i, len_err); end
    end
    rready = 1'b1;
    tick();
    rlast = 1'b1;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    total++; if (len_err !== 1'b0) begin bad++; $display("FAIL bp_final_len_err: got %b want 0", len_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_data;
    m0_addr(2'd1, 8'd3);
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b0;
    repeat (2) tick();
    #2 rst_ni = 1'b0;
    #1;
    total++; if ({m1_rgrnt, m0_rgrnt} !== 2'b00) begin bad++; $display("FAIL rst_mid_grant: got %b want 00", {m1_rgrnt, m0_rgrnt}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    total++; if (s_rsel !== 2'd0) begin bad++; $display("FAIL rst_mid_sel: got %0d want 0", s_rsel); end
    total++; if (len_err !== 1'b0) begin bad++; $display("FAIL rst_mid_len_err: got %b want 0", len_err); end
    rvalid = 1'b0;
    tick();
    #2 rst_ni = 1'b1;
    m0_arsel = 2'd2; m1_arsel = 2'd3;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    tick();
    total++; if ({m1_rgrnt, m0_rgrnt} !== 2'b01) begin bad++; $display("FAIL rst_first_grant: got %b want 01", {m1_rgrnt, m0_rgrnt}); end
    total++; if (s_rsel !== 2'd2) begin bad++; $display("FAIL rst_first_sel: got %0d want 2", s_rsel); end
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_short_burst();
    test_long_burst();
    test_backpressure();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Sequencing arbiter for the shared read path of the two-master / four-slave AXI interconnect. It grants the AR channel to the CPU (m0) or the DMAC (m1) with round-robin fairness. It holds that grant through the address handshake and the entire R burst, and drives the select lines for the AR/R muxes. It allows one outstanding read at a time, checks burst length against RLAST, and sits beside the AR/R mux instances inside the interconnect top.

## Interface
Parameters:
- LEN_BITS, default `LEN_BITS: width of ARLEN.
- SEL_BITS, default 2: slave-select width, taken from the top ARADDR bits.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- m0_arvalid, m1_arvalid  in  1 each  raw ARVALID from each master.
- m0_arsel, m1_arsel  in  SEL_BITS each  ARADDR[`ADDR_WIDTH-1 -: SEL_BITS] of each master.
- m0_arlen, m1_arlen  in  LEN_BITS each  ARLEN of each master.
- arvalid, arready  in  1 each  muxed AR handshake at the slave side.
- rvalid, rready, rlast  in  1 each  muxed R handshake at the master side.
- m0_rgrnt, m1_rgrnt  out  1 each  one-hot grant that drives the AR and R muxes.
- s_rsel  out  SEL_BITS  slave index for the current transaction.
- busy  out  1  high in any state other than IDLE.
- len_err  out  1  one-cycle pulse on a burst-length mismatch.

## Operation
- Registered FSM with states IDLE, ADDR and DATA.
- Reset values:
  - state = IDLE, m0_rgrnt = m1_rgrnt = 0, s_rsel = 0, busy = 0, len_err = 0.
  - Priority pointer last_m1 = 1, so m0 wins the first contest.
  - Beat counter = 0, latched length = 0.
- IDLE:
  - If exactly one master has arvalid, grant it.
  - If both have arvalid, grant the master that was not granted last.
  - On a grant: set the grant flop, capture that master's arsel into s_rsel and its arlen into len_q, and go to ADDR.
  - With no requests, stay in IDLE with the grants low.
- ADDR:
  - Grant and s_rsel are held stable.
  - On arvalid && arready: clear the beat counter and go to DATA.
  - If the granted master drops arvalid (protocol violation), the grant is still held; there is no re-arbitration.
- DATA:
  - Every rvalid && rready increments the beat counter (width LEN_BITS+1, so it cannot wrap).
  - On the beat with rvalid && rready && rlast:
    - Pulse len_err the next cycle if beat count ≠ len_q; the expected beat count is len_q + 1 beats, indexed 0..len_q.
    - Update last_m1 to the granted master, drop both grants, and go to IDLE.
  - If the beat count passes len_q without rlast, pulse len_err once. Keep counting (saturating at its maximum) and stay in DATA until rlast.
- The grant is never dropped mid-burst. R responses from the non-granted master's slave cannot reach either master.
- Reset asserted mid-transaction returns every flop to its reset value immediately. Outputs go low asynchronously.

## Timing
- A request seen in IDLE at edge N gives its grant high after edge N; the AR mux forwards ARVALID in cycle N+1.
- ADDR → DATA takes one edge after the handshake. DATA → IDLE takes one edge after the RLAST beat.
- At least one IDLE cycle separates consecutive transactions.
- Minimum transaction occupancy is 1 (IDLE) + 1 (ADDR) + (len+1) data beats.
- Grants are one-hot or zero at every cycle. s_rsel changes only on the IDLE→ADDR edge.
- len_err is registered and lasts exactly one cycle per violation; at most one pulse per transaction.

## Structure
- The shared interconnect package holds:
  - the FSM state typedef (IDLE/ADDR/DATA);
  - the SEL_BITS constant, reused by the AW side;
  - the encoding of slave indices (s0..s3).
- Widths come from the existing define file.
- One natural sub-module: axi_rr_pick2, the combinational two-way round-robin chooser (inputs: two requests plus last_m1; output: one-hot pick). The write-side arbiter reuses it.

## Test plan
- Single request: m0 requests, arsel=1, arlen=3; arready after 2 cycles, 4 beats with RLAST on beat 3 → m0_rgrnt high from cycle 1 to the RLAST edge, s_rsel=1, len_err never asserted.
- Contention: both masters request continuously, arlen=0 → grants alternate m0, m1, m0, m1 after reset; each transaction is followed by one IDLE cycle.
- Short burst: arlen=3, RLAST on beat 1 → len_err pulses one cycle, then IDLE.
- Long burst: arlen=1, RLAST on beat 4 → one len_err pulse when the 3rd beat is counted; grant held until beat 4.
- R backpressure: rready low for 5 cycles mid-burst → counter frozen, grant held, no error.
- Reset mid-DATA: rst_ni low during beat 2 → all outputs 0 immediately; first grant after release goes to m0 when both masters request.
